imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 16384, instruction memory size in bytes.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 start  input  1  one-cycle request to begin a load session.
REQ-005 base_addr  input  32  byte address of the first word, sampled on accepted start.
REQ-006 word_count  input  16  number of 32-bit words to load, sampled on accepted start.
REQ-007 in_valid  input  1  source holds a valid word on in_data.
REQ-008 in_data  input  32  instruction word, MSB first in memory.
REQ-009 in_ready  output  1  loader accepts in_data this cycle.
REQ-010 mem_we  output  1  byte write strobe to instruction memory.
REQ-011 mem_addr  output  32  byte address for the write.
REQ-012 mem_wdata  output  8  byte to write.
REQ-013 busy  output  1  high from accepted start until the session ends.
REQ-014 done  output  1  one-cycle pulse on successful completion.
REQ-015 err  output  1  sticky error flag; cleared by the next accepted start.

Function
REQ-016 States: IDLE, FETCH, WRITE, FIN; all outputs registered.
REQ-017 IDLE: in_ready=0, mem_we=0. start=1 is accepted: base_addr, word_count latched; cur_addr=base_addr; words_done=0; err=0; busy=1.
REQ-018 On accepted start with base_addr[1:0]!=0: err=1 and busy=0 next cycle; state stays IDLE; no writes.
REQ-019 On accepted start with word_count=0: go to FIN; done pulses one cycle later; no writes.
REQ-020 Otherwise go to FETCH.
REQ-021 FETCH: in_ready=1. Transfer occurs only when in_valid=1 and in_ready=1 in the same cycle. The word is captured, byte index set to 0, and the state moves to WRITE.
REQ-022 FETCH bound check, made before asserting in_ready: if cur_addr > DEPTH-4, set err=1, drive in_ready=0, return to IDLE, and drop busy. No word is consumed.
REQ-023 WRITE: four consecutive cycles with mem_we=1, mem_addr=cur_addr+idx, and idx=0..3. mem_wdata is word[31:24], [23:16], [15:8], [7:0] in that order (big-endian, matching the fetch-side byte assembly). in_ready=0 throughout.
REQ-024 After idx=3: cur_addr += 4 and words_done += 1. If words_done equals word_count, go to FIN; otherwise go to FETCH.
REQ-025 Throughput: 5 cycles per word, with in_valid continuously high.
REQ-026 FIN: done=1 for exactly one cycle; busy=0 from the same cycle; state returns to IDLE.
REQ-027 start while busy=1 is ignored and does not alter latched values.
REQ-028 in_valid low in FETCH: wait indefinitely; no timeout.
REQ-029 mem_addr arithmetic is 32-bit. cur_addr never wraps, because REQ-022 aborts first.
REQ-030 mem_addr and mem_wdata hold their last values when mem_we=0.

Reset
REQ-031 rst_n=0 at a clock edge forces, on the next cycle: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, and all counters to 0.
REQ-032 Reset during WRITE stops writes immediately; the partially written word stays in memory. No done pulse is generated.
REQ-033 After rst_n returns high, a new start is required before any further activity.

Verification
REQ-034 start, base=100, count=1, in_data=0x48080000 -> exactly 4 writes: (100,0x48), (101,0x08), (102,0x00), (103,0x00). done pulses 1 cycle after the last write; busy=0.
REQ-035 start, base=700, count=3, words 0x48080000, 0x25080002, 0x31080002 with in_valid always high -> 12 writes to addresses 700..711 in order. in_ready is high exactly 3 cycles; done occurs 16 cycles after start.
REQ-036 start, base=102 -> err=1 next cycle; no mem_we; in_ready never asserted. A following start with base=200, count=1 -> err cleared and a normal load occurs.
REQ-037 start, base=16380, count=2 -> first word written at 16380..16383. In the second FETCH: err=1, in_ready stays 0, busy drops, and no done pulse.
REQ-038 start, count=0 -> no writes; a single done pulse.
REQ-039 rst_n=0 asserted on the 2nd WRITE cycle of base=200, count=1 -> only addr 200 is written; outputs return to reset values. in_valid held low in FETCH for 10 cycles -> no writes and busy stays 1.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction-memory loader: pulls 32-bit words from a valid/ready source and
// writes them big-endian, one byte per cycle, starting at a word-aligned base.
module imem_loader #(
  parameter int DEPTH = 16384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] word_count,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, FIN} state_t;

  localparam logic [31:0] LIMIT = 32'(DEPTH - 4);

  state_t      state;
  logic [31:0] cur_addr;
  logic [31:0] word;
  logic [15:0] count;
  logic [15:0] words_done;
  logic [1:0]  idx;

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  function automatic logic in_range(input logic [31:0] addr);
    return (addr <= LIMIT);
  endfunction

  // Session FSM; in_ready is registered with the bound check already applied,
  // so a FETCH entered with in_ready low means the next word would overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_addr   <= 32'd0;
      word       <= 32'd0;
      count      <= 16'd0;
      words_done <= 16'd0;
      idx        <= 2'd0;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 8'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b0;
          mem_we   <= 1'b0;
          if (start) begin
            count      <= word_count;
            cur_addr   <= base_addr;
            words_done <= 16'd0;
            idx        <= 2'd0;
            err        <= 1'b0;
            if (base_addr[1:0] != 2'b00) begin
              err  <= 1'b1;
              busy <= 1'b0;
            end else if (word_count == 16'd0) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              busy     <= 1'b1;
              in_ready <= in_range(base_addr);
              state    <= FETCH;
            end
          end
        end
        FETCH: begin
          if (!in_ready) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (in_valid) begin
            word      <= in_data;
            in_ready  <= 1'b0;
            mem_we    <= 1'b1;
            mem_addr  <= cur_addr;
            mem_wdata <= in_data[31:24];
            idx       <= 2'd0;
            state     <= WRITE;
          end
        end
        WRITE: begin
          if (idx == 2'd3) begin
            mem_we     <= 1'b0;
            cur_addr   <= cur_addr + 32'd4;
            words_done <= words_done + 16'd1;
            if (words_done + 16'd1 == count) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              in_ready <= in_range(cur_addr + 32'd4);
              state    <= FETCH;
            end
          end else begin
            idx       <= idx + 2'd1;
            mem_addr  <= cur_addr + {30'd0, idx + 2'd1};
            mem_wdata <= pick_byte(word, idx + 2'd1);
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a session-level model predicts the byte
// write stream and the session outcome; a per-cycle monitor checks the DUT.
module tb_imem_loader;
  localparam int DEPTH = 16384;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = 32'd0;
  logic [15:0] word_count = 16'd0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_ready, mem_we, busy, done, err;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  logic [39:0] exp_q[$];
  logic [39:0] dut_log[$];
  logic [31:0] src_words[$];
  logic [31:0] last_addr = 32'd0;
  logic [7:0]  last_data = 8'd0;
  logic        rst_seen = 1'b1;
  int          last_done_cyc;
  int          last_ready_cycles;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) rst_seen <= !rst_n;

  // Per-cycle monitor: reset values, expected byte stream, hold when idle.
  always @(negedge clk) begin
    if (rst_seen) begin
      chk("reset_outputs", {mem_we, in_ready, busy, done, err, mem_addr, mem_wdata},
          {5'b0, 32'd0, 8'd0});
      last_addr = 32'd0;
      last_data = 8'd0;
    end else if (mem_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {mem_addr, mem_wdata}, 40'd0);
        n_pass += 0;
      end else begin
        chk("write", {mem_addr, mem_wdata}, exp_q.pop_front());
      end
      dut_log.push_back({mem_addr, mem_wdata});
      last_addr = mem_addr;
      last_data = mem_wdata;
    end else begin
      chk("hold", {mem_addr, mem_wdata}, {last_addr, last_data});
    end
    if (done) chk("done_busy", busy, 1'b0);
  end

  task automatic run_session(input logic [31:0] base, input int count, input int vprob,
                             input int low_cycles, input bit inject);
    bit  aligned;
    int  n_ok, cyc, widx, hs, ready_cycles, done_cyc, budget;
    longint a;
    aligned = (base[1:0] == 2'b00);
    n_ok = 0;
    if (aligned) begin
      for (int i = 0; i < count; i++) begin
        a = longint'(base) + 4 * i;
        if (a <= DEPTH - 4) n_ok++;
        else break;
      end
    end
    while (src_words.size() < count) src_words.push_back($urandom);
    exp_q.delete();
    dut_log.delete();
    for (int i = 0; i < n_ok; i++)
      for (int k = 0; k < 4; k++)
        exp_q.push_back({base + 32'(4 * i + k), src_words[i][31 - 8 * k -: 8]});

    @(negedge clk);
    start = 1'b1; base_addr = base; word_count = 16'(count); in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; widx = 0; hs = 0; ready_cycles = 0; done_cyc = -1;
    budget = 100 * count + 60;
    while (cyc < budget) begin
      if (done) begin done_cyc = cyc; break; end
      if (err) break;
      if (in_ready) ready_cycles++;
      if (cyc <= low_cycles) chk("busy_wait", busy, 1'b1);
      start = 1'b0;
      if (inject && cyc == 3 && busy) begin
        start = 1'b1; base_addr = $urandom; word_count = 16'($urandom_range(1, 9));
      end
      in_valid = (cyc > low_cycles) && ($urandom_range(99) < vprob);
      in_data = (widx < src_words.size()) ? src_words[widx] : $urandom;
      if (in_valid && in_ready) begin hs++; widx++; end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (cyc >= budget) chk("timeout", 1'b1, 1'b0);
    chk("done_seen", done_cyc >= 0, aligned && n_ok == count);
    chk("err_flag", err, !aligned || n_ok < count);
    chk("busy_end", busy, 1'b0);
    chk("writes_left", exp_q.size(), 0);
    chk("handshakes", hs, n_ok);
    if (vprob == 100 && low_cycles == 0) begin
      chk("ready_cycles", ready_cycles, n_ok);
      if (done_cyc >= 0) chk("latency", done_cyc, 5 * count + 1);
    end
    last_done_cyc = done_cyc;
    last_ready_cycles = ready_cycles;
    @(negedge clk);
    chk("done_pulse", done, 1'b0);
    chk("err_sticky", err, !aligned || n_ok < count);
    src_words.delete();
  endtask

  initial begin
    logic [31:0] b;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    src_words = '{32'h48080000};
    run_session(32'd100, 1, 100, 0, 1'b0);
    chk("r034_n", dut_log.size(), 4);
    if (dut_log.size() == 4) begin
      chk("r034_w0", dut_log[0], {32'd100, 8'h48});
      chk("r034_w1", dut_log[1], {32'd101, 8'h08});
      chk("r034_w2", dut_log[2], {32'd102, 8'h00});
      chk("r034_w3", dut_log[3], {32'd103, 8'h00});
    end

    src_words = '{32'h48080000, 32'h25080002, 32'h31080002};
    run_session(32'd700, 3, 100, 0, 1'b0);
    chk("r035_done16", last_done_cyc, 16);
    chk("r035_ready3", last_ready_cycles, 3);
    chk("r035_n", dut_log.size(), 12);
    if (dut_log.size() == 12) begin
      chk("r035_first", dut_log[0], {32'd700, 8'h48});
      chk("r035_last", dut_log[11], {32'd711, 8'h02});
    end

    run_session(32'd102, 1, 100, 0, 1'b0);
    run_session(32'd200, 1, 100, 0, 1'b0);
    run_session(32'd16380, 2, 100, 0, 1'b0);
    run_session(32'd64, 0, 100, 0, 1'b0);
    run_session(32'd300, 1, 100, 10, 1'b0);

    // Reset lands on the edge that would start the second byte of a word.
    src_words = '{$urandom};
    exp_q.delete();
    exp_q.push_back({32'd200, src_words[0][31:24]});
    @(negedge clk);
    start = 1'b1; base_addr = 32'd200; word_count = 16'd1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = src_words[0];
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_first_write", {mem_we, mem_addr}, {1'b1, 32'd200});
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", {busy, in_ready, done}, 3'b000);
    end
    in_valid = 1'b0;
    chk("rst_writes_left", exp_q.size(), 0);
    src_words.delete();

    for (int s = 0; s < 40; s++) begin
      case ($urandom_range(9))
        0:       b = ($urandom_range(0, 4000) * 4) + 32'($urandom_range(1, 3));
        1:       b = 32'(DEPTH - 4 * $urandom_range(0, 3));
        2:       b = 32'(DEPTH + 4 * $urandom_range(0, 50));
        default: b = 32'($urandom_range(0, (DEPTH - 64) / 4) * 4);
      endcase
      run_session(b, $urandom_range(0, 5), $urandom_range(0, 1) ? 100 : $urandom_range(30, 90),
                  $urandom_range(0, 3) == 0 ? $urandom_range(1, 6) : 0, $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
